// File: rtl/pt_feedback_pkg.sv
// pt_feedback_pkg: shared constants and helpers for the feedback path blocks.
package pt_feedback_pkg;
  localparam int unsigned LOG2_MAX_DECIMATION_DEF = 4;
  function automatic int unsigned acc_width(input int unsigned w, input int unsigned l);
    return w + l;
  endfunction
  function automatic int unsigned clamp_k(input int unsigned k, input int unsigned kmax);
    return (k > kmax) ? kmax : k;
  endfunction
endpackage

// File: rtl/boxcar_decimator.sv
// boxcar_decimator: averages frames of 2^k signed samples into one output strobe.
module boxcar_decimator
  import pt_feedback_pkg::*;
#(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned LOG2_MAX_DECIMATION = LOG2_MAX_DECIMATION_DEF,
  localparam int unsigned KW = $clog2(LOG2_MAX_DECIMATION + 1),
  localparam int unsigned AW = acc_width(WIDTH, LOG2_MAX_DECIMATION)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ce_i,
  input  logic [KW-1:0]           log2_decimation_i,
  input  logic signed [WIDTH-1:0] data_i,
  output logic                    data_valid_o,
  output logic signed [WIDTH-1:0] data_o
);
  logic [KW-1:0] k_q, k_new;
  logic [LOG2_MAX_DECIMATION-1:0] cnt_q;
  logic signed [AW-1:0] acc_q, sum, avg;
  logic last;
  always_comb begin
    k_new = KW'(clamp_k(32'(log2_decimation_i), LOG2_MAX_DECIMATION));
    sum   = acc_q + {{LOG2_MAX_DECIMATION{data_i[WIDTH-1]}}, data_i};
    avg   = sum >>> k_q;
    last  = cnt_q == LOG2_MAX_DECIMATION'((32'd1 << k_q) - 32'd1);
  end
  // A change of k aborts the frame and drops the coincident sample.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      k_q          <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
    end else begin
      data_valid_o <= 1'b0;
      if (k_new != k_q) begin
        k_q   <= k_new;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (ce_i && last) begin
        data_o       <= avg[WIDTH-1:0];
        data_valid_o <= 1'b1;
        acc_q        <= '0;
        cnt_q        <= '0;
      end else if (ce_i) begin
        acc_q <= sum;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: doc/boxcar_decimator.md
# boxcar_decimator

Averaging decimator that reduces the sample rate by a programmable power of two before the feedback delay and filter stages. It consumes a stream of signed samples qualified by `ce_i`. It emits one averaged sample per frame of 2^k input samples, with a single-cycle `data_valid_o` strobe. That strobe drives the clock-enable input of the downstream delay line directly.

## Interface
- `WIDTH`, 14: sample width, signed two's complement, in and out.
- `LOG2_MAX_DECIMATION`, 4: largest supported k; the maximum decimation factor is 2^LOG2_MAX_DECIMATION.
- `clk_i`  in  1: single clock for the block.
- `rst_i`  in  1: reset, asynchronous, active-high.
- `ce_i`  in  1: input sample qualifier; `data_i` is consumed only when high.
- `log2_decimation_i`  in  $clog2(LOG2_MAX_DECIMATION+1): requested k.
- `data_i`  in  WIDTH: signed input sample.
- `data_valid_o`  out  1: one-cycle strobe marking a new `data_o`.
- `data_o`  out  WIDTH: signed averaged sample; held between strobes.

## Operation
- **Working value of k.** `k_q` is the registered value of `log2_decimation_i`, clamped to LOG2_MAX_DECIMATION. Values above the maximum behave exactly as the maximum.
- **Accumulator.** `acc_q` is signed, WIDTH+LOG2_MAX_DECIMATION bits wide.
  - It must never overflow, for any k and any input sequence.
  - Each input sample is sign-extended before it is added.
- **Sample counter.** `cnt_q` is LOG2_MAX_DECIMATION bits wide and counts `ce_i` samples within the current frame.
- **Sample with `ce_i` high, not the last of the frame** (`cnt_q` != 2^k_q − 1):
  - `acc_q <= acc_q + data_i`
  - `cnt_q <= cnt_q + 1`
- **Sample with `ce_i` high, last of the frame** (`cnt_q` == 2^k_q − 1):
  - `data_o <= (acc_q + data_i) >>> k_q`
  - `data_valid_o <= 1`
  - `acc_q <= 0`
  - `cnt_q <= 0`
- **Output arithmetic.**
  - The shift is arithmetic and truncates toward −∞.
  - Only the low WIDTH bits of the shifted sum are kept. The shifted sum always fits in WIDTH bits, so no saturation is required.
- **k = 0.** Every `ce_i` sample is the last of its frame, so the block is a one-cycle registered pass-through with `data_valid_o` = `ce_i` delayed by one cycle.
- **`ce_i` low.** Nothing changes and `data_valid_o` is 0. Gaps of any length inside a frame are allowed.
- **Change of k** (clamped `log2_decimation_i` != `k_q`):
  - Abort the frame: `acc_q <= 0`, `cnt_q <= 0`, `k_q <=` new value.
  - Emit no output strobe. Discard any `ce_i` sample arriving in the same cycle.
  - `data_o` keeps its last value.
- **Priority within a cycle:** reset, then change of k, then the frame-complete update, then the accumulate update.

## Timing
- **Reset values:** `data_o` = 0, `data_valid_o` = 0, `acc_q` = 0, `cnt_q` = 0, `k_q` = 0.
- **First cycle after reset.** If `log2_decimation_i` is nonzero, the first cycle after reset is a change-of-k cycle and its sample is discarded.
- **Latency:** 1 clock from the cycle that carries the last sample of a frame to `data_valid_o` high with the new `data_o`.
- **Strobe width:** `data_valid_o` is high for exactly one cycle per frame and is never high in two consecutive cycles unless k = 0.
- **Back-to-back frames:** with `ce_i` held high and k > 0, strobes occur every 2^k cycles with no dead cycle between frames.
- **Reset mid-frame:** the partial frame is lost, and no strobe occurs until a full 2^k samples have been accepted after release.
- **Throughput:** the downstream block must accept one sample per strobe; there is no backpressure.

## Structure
- **Shared package `pt_feedback_pkg`:**
  - the accumulator-width function (WIDTH + LOG2_MAX_DECIMATION)
  - the k-clamp helper
  - the default LOG2_MAX_DECIMATION constant, shared with the delay-line instantiation
- **Sub-modules:** none; a single module containing a counter, an accumulator and an output register is natural.

## Test plan
- **Basic average, positive.** k=2, `ce_i` always high, `data_i` = 1,2,3,4 → one strobe, 1 cycle after the sample 4, with `data_o` = 2 (10>>>2).
- **Basic average, negative.** k=2, `data_i` = −1,−2,−3,−4 → `data_o` = −3 (−10>>>2 truncates toward −∞).
- **Full-scale limits.**
  - k=4 with 16 samples of 8191 → `data_o` = 8191.
  - k=4 with 16 samples of −8192 → `data_o` = −8192.
  - No overflow in either case.
- **k = 0 with gaps.** k=0, `ce_i` pattern 1,0,1,1, data 5,x,−7,9 → strobes in cycles 1, 3 and 4 carrying 5, −7 and 9.
- **Change of k and clamp.** k=3, then after 5 samples k changes to 1 → no strobe; the next 2 samples 6,8 → `data_o` = 7. Then request k=7 → the block behaves as k=4 (16-sample frames).
- **Reset mid-frame.** k=2, 3 samples, assert `rst_i` asynchronously between clock edges → `data_o`/`data_valid_o` go to 0 immediately; after release, 4 samples of 12 → a single strobe with `data_o` = 12.
